// File: rtl/fetch_stage.sv
// Instruction fetch for one ECC_CPU core: owns PC and lane mask, keeps one read in
// flight, and buffers returned words in a 2-entry packet queue feeding decode.
module fetch_stage #(
  parameter int              CORE_ID  = 0,
  parameter int              PC_W     = 64,
  parameter int              LANES    = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [PC_W-1:0]  mem_req_addr,
  input  logic             mem_rsp_valid,
  input  logic [31:0]      mem_rsp_data,
  output logic             dec_pkt_valid,
  input  logic             dec_pkt_ready,
  output logic [PC_W-1:0]  dec_pkt_pc,
  output logic [31:0]      dec_pkt_insn,
  output logic [LANES-1:0] dec_pkt_mask,
  input  logic             redir_valid,
  input  logic [PC_W-1:0]  redir_pc,
  input  logic [LANES-1:0] redir_mask,
  input  logic             halt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]       state_r;
  logic [PC_W-1:0]  pc_r;
  logic [LANES-1:0] mask_r;
  logic [PC_W-1:0]  tag_pc_r;
  logic [LANES-1:0] tag_mask_r;
  logic             outstanding_r;
  logic             drop_r;
  logic [PC_W-1:0]  q_pc_r   [2];
  logic [31:0]      q_insn_r [2];
  logic [LANES-1:0] q_mask_r [2];
  logic             head_r;
  logic             tail_r;
  logic [1:0]       count_r;

  logic req_valid_s;
  logic req_fire_s;
  logic rsp_take_s;
  logic redir_s;
  logic flush_s;
  logic push_s;
  logic pop_s;
  logic unused_s;

  // Handshake qualification; a redirect or halt flushes the queue and blocks push/pop.
  always_comb begin
    req_valid_s = 1'b0;
    redir_s     = 1'b0;
    flush_s     = 1'b0;
    if (rst_n && (state_r == ST_RUN) && !outstanding_r && (count_r < 2'd2) && !redir_valid) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    if (redir_valid && !halt && (state_r != ST_HALTED)) begin
      redir_s = 1'b1;
    end else begin
      redir_s = 1'b0;
    end
    if (halt || redir_s || (state_r == ST_HALTED)) begin
      flush_s = 1'b1;
    end else begin
      flush_s = 1'b0;
    end
    req_fire_s = req_valid_s && mem_req_ready;
    rsp_take_s = mem_rsp_valid && outstanding_r;
    push_s     = rsp_take_s && !drop_r && !flush_s;
    pop_s      = (count_r != 2'd0) && dec_pkt_ready && !flush_s;
  end

  assign mem_req_valid = req_valid_s;
  assign mem_req_addr  = pc_r;
  assign dec_pkt_valid = (count_r != 2'd0);
  assign dec_pkt_pc    = q_pc_r[head_r];
  assign dec_pkt_insn  = q_insn_r[head_r];
  assign dec_pkt_mask  = q_mask_r[head_r];
  assign unused_s      = ^redir_pc[1:0];

  // Control state: halt is terminal and outranks everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
    end else if (halt) begin
      state_r <= ST_HALTED;
    end else begin
      case (state_r)
        ST_RUN:    state_r <= req_fire_s ? ST_WAIT : ST_RUN;
        ST_WAIT:   state_r <= rsp_take_s ? ST_RUN : ST_WAIT;
        ST_HALTED: state_r <= ST_HALTED;
        default:   state_r <= ST_RUN;
      endcase
    end
  end

  // In-flight bookkeeping; a flushed request's late response is marked for discard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_r <= 1'b0;
      drop_r        <= 1'b0;
    end else begin
      if (req_fire_s) begin
        outstanding_r <= 1'b1;
      end else if (rsp_take_s) begin
        outstanding_r <= 1'b0;
      end else begin
        outstanding_r <= outstanding_r;
      end
      if ((halt || redir_s) && outstanding_r && !mem_rsp_valid) begin
        drop_r <= 1'b1;
      end else if (halt && req_fire_s) begin
        drop_r <= 1'b1;
      end else if (rsp_take_s) begin
        drop_r <= 1'b0;
      end else begin
        drop_r <= drop_r;
      end
    end
  end

  // PC, lane mask and the tag travelling with the outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= {RESET_PC[PC_W-1:2], 2'b00};
      mask_r     <= {LANES{1'b1}};
      tag_pc_r   <= {PC_W{1'b0}};
      tag_mask_r <= {LANES{1'b0}};
    end else if (req_fire_s) begin
      tag_pc_r   <= pc_r;
      tag_mask_r <= mask_r;
      pc_r       <= pc_r + {{(PC_W-3){1'b0}}, 3'd4};
    end else if (redir_s) begin
      pc_r   <= {redir_pc[PC_W-1:2], 2'b00};
      mask_r <= redir_mask;
    end else begin
      pc_r   <= pc_r;
      mask_r <= mask_r;
    end
  end

  // Two-entry packet queue toward decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      count_r <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        q_pc_r[i]   <= {PC_W{1'b0}};
        q_insn_r[i] <= 32'd0;
        q_mask_r[i] <= {LANES{1'b0}};
      end
    end else if (flush_s) begin
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (push_s) begin
        q_pc_r[tail_r]   <= tag_pc_r;
        q_insn_r[tail_r] <= mem_rsp_data;
        q_mask_r[tail_r] <= tag_mask_r;
        tail_r           <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  fetch_stage_chk #(.CORE_ID(CORE_ID)) u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_rsp_valid (mem_rsp_valid),
    .outstanding   (outstanding_r),
    .drop          (drop_r)
  );

endmodule

// Simulation checks for fetch_stage: memory must never answer an unissued read.
module fetch_stage_chk #(
  parameter int CORE_ID = 0
) (
  input logic clk,
  input logic rst_n,
  input logic mem_rsp_valid,
  input logic outstanding,
  input logic drop
);

  property p_no_stray_rsp;
    @(posedge clk) disable iff (!rst_n) mem_rsp_valid |-> (outstanding || drop);
  endproperty

  a_no_stray_rsp: assert property (p_no_stray_rsp)
    else $error("fetch_stage[%0d]: response with no request outstanding", CORE_ID);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queue-based reference model checked every cycle,
// plus hand-computed expectations at the key points of each scenario.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        dec_pkt_valid;
  logic        dec_pkt_ready;
  logic [63:0] dec_pkt_pc;
  logic [31:0] dec_pkt_insn;
  logic [7:0]  dec_pkt_mask;
  logic        redir_valid;
  logic [63:0] redir_pc;
  logic [7:0]  redir_mask;
  logic        halt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_stage #(.CORE_ID(0), .PC_W(64), .LANES(8), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .dec_pkt_valid(dec_pkt_valid), .dec_pkt_ready(dec_pkt_ready), .dec_pkt_pc(dec_pkt_pc),
    .dec_pkt_insn(dec_pkt_insn), .dec_pkt_mask(dec_pkt_mask),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_mask(redir_mask), .halt(halt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: packets waiting for decode, the read in flight, and discard/halt state.
  typedef struct {
    logic [63:0] pc;
    logic [31:0] insn;
    logic [7:0]  mask;
  } pkt_t;

  pkt_t        mq[$];
  logic [63:0] m_pc;
  logic [7:0]  m_mask;
  logic [63:0] m_tag_pc;
  logic [7:0]  m_tag_mask;
  bit          m_busy;
  bit          m_drop;
  bit          m_halted;

  task automatic model_reset();
    m_pc = 64'd0; m_mask = 8'hFF; mq.delete();
    m_busy = 1'b0; m_drop = 1'b0; m_halted = 1'b0;
    m_tag_pc = 64'd0; m_tag_mask = 8'd0;
  endtask

  task automatic model_step(input bit exp_req);
    bit   fire;
    bit   took;
    bit   flush;
    pkt_t p;
    fire  = exp_req && mem_req_ready;
    took  = mem_rsp_valid && m_busy;
    flush = halt || redir_valid || m_halted;
    if (!flush && mq.size() != 0 && dec_pkt_ready) void'(mq.pop_front());
    if (took) begin
      m_busy = 1'b0;
      if (m_drop) m_drop = 1'b0;
      else if (!flush) begin
        p.pc = m_tag_pc; p.insn = mem_rsp_data; p.mask = m_tag_mask;
        mq.push_back(p);
      end
    end
    if (fire) begin
      m_busy = 1'b1; m_tag_pc = m_pc; m_tag_mask = m_mask; m_pc = m_pc + 64'd4;
    end
    if (halt) begin
      m_halted = 1'b1;
      if (m_busy) m_drop = 1'b1;
    end else if (redir_valid && !m_halted) begin
      m_pc = {redir_pc[63:2], 2'b00}; m_mask = redir_mask;
      if (m_busy) m_drop = 1'b1;
    end
    if (flush) mq.delete();
  endtask

  // Every-cycle comparison against the model, then advance it with this cycle's inputs.
  initial begin
    bit exp_req;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        check("rst_req_valid", 64'(mem_req_valid), 64'd0);
        check("rst_pkt_valid", 64'(dec_pkt_valid), 64'd0);
      end else begin
        exp_req = !m_halted && !m_busy && (mq.size() < 2) && !redir_valid;
        check("cmp_req_valid", 64'(mem_req_valid), 64'(exp_req));
        if (exp_req) check("cmp_req_addr", mem_req_addr, m_pc);
        check("cmp_pkt_valid", 64'(dec_pkt_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
          check("cmp_pkt_pc", dec_pkt_pc, mq[0].pc);
          check("cmp_pkt_insn", 64'(dec_pkt_insn), 64'(mq[0].insn));
          check("cmp_pkt_mask", 64'(dec_pkt_mask), 64'(mq[0].mask));
        end
        model_step(exp_req);
      end
    end
  end

  // Memory stub: with auto_mem set, answers each accepted read one cycle later with addr+1.
  bit          auto_mem;
  bit          fire_s;
  logic [63:0] fire_addr;

  task automatic tick();
    @(negedge clk);
    fire_s    = mem_req_valid && mem_req_ready;
    fire_addr = mem_req_addr;
    @(posedge clk);
    #1;
    halt        = 1'b0;
    redir_valid = 1'b0;
    if (auto_mem) begin
      mem_rsp_valid = fire_s;
      mem_rsp_data  = fire_addr[31:0] + 32'd1;
    end else begin
      mem_rsp_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0;
    dec_pkt_ready = 1'b1; redir_valid = 1'b0; redir_pc = 64'd0; redir_mask = 8'd0;
    halt = 1'b0; auto_mem = 1'b1;
    @(posedge clk); #1;
    tick(); tick();
    #1;
    check("reset_req_valid", 64'(mem_req_valid), 64'd0);
    check("reset_pkt_valid", 64'(dec_pkt_valid), 64'd0);
    check("reset_pkt_pc", dec_pkt_pc, 64'd0);
    check("reset_pkt_insn", 64'(dec_pkt_insn), 64'd0);
    check("reset_pkt_mask", 64'(dec_pkt_mask), 64'd0);

    // Streaming with a 1-cycle memory and decode always ready.
    tick(); rst_n = 1'b1; #1;
    check("t1_first_req", 64'(mem_req_valid), 64'd1);
    check("t1_first_addr", mem_req_addr, 64'd0);
    tick(); #1;
    check("t1_wait_no_req", 64'(mem_req_valid), 64'd0);
    tick(); #1;
    check("t1_pkt0_pc", dec_pkt_pc, 64'd0);
    check("t1_pkt0_insn", 64'(dec_pkt_insn), 64'd1);
    check("t1_pkt0_mask", 64'(dec_pkt_mask), 64'hFF);
    check("t1_req4_addr", mem_req_addr, 64'd4);
    repeat (12) tick();
    #1;
    check("t1_pkt6_pc", dec_pkt_pc, 64'h18);
    check("t1_pkt6_insn", 64'(dec_pkt_insn), 64'h19);
    check("t1_req_1c", mem_req_addr, 64'h1C);

    // Decode stalled: queue fills with pc 0 and 4, then one pop lets pc 8 issue.
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; dec_pkt_ready = 1'b0;
    repeat (4) tick();
    #1;
    check("t2_full_head", dec_pkt_pc, 64'd0);
    check("t2_full_no_req", 64'(mem_req_valid), 64'd0);
    tick(); tick(); #1;
    check("t2_still_no_req", 64'(mem_req_valid), 64'd0);
    dec_pkt_ready = 1'b1;
    tick(); dec_pkt_ready = 1'b0; auto_mem = 1'b0; #1;
    check("t2_head_after_pop", dec_pkt_pc, 64'd4);
    check("t2_req8_valid", 64'(mem_req_valid), 64'd1);
    check("t2_req8_addr", mem_req_addr, 64'd8);

    // Redirect while the read for 8 is outstanding: its response must be dropped.
    tick();
    redir_valid = 1'b1; redir_pc = 64'h100; redir_mask = 8'h0F; #1;
    check("t3_redir_no_req", 64'(mem_req_valid), 64'd0);
    tick(); #1;
    check("t3_flushed", 64'(dec_pkt_valid), 64'd0);
    check("t3_drop_pending", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h9; auto_mem = 1'b1; dec_pkt_ready = 1'b1;
    tick(); #1;
    check("t3_req_100", mem_req_addr, 64'h100);
    check("t3_dropped_not_pushed", 64'(dec_pkt_valid), 64'd0);
    tick(); tick(); #1;
    check("t3_pkt_100_pc", dec_pkt_pc, 64'h100);
    check("t3_pkt_100_insn", 64'(dec_pkt_insn), 64'h101);
    check("t3_pkt_100_mask", 64'(dec_pkt_mask), 64'h0F);
    tick(); tick(); #1;
    check("t3_pkt_104_pc", dec_pkt_pc, 64'h104);
    check("t3_pkt_104_mask", 64'(dec_pkt_mask), 64'h0F);
    dec_pkt_ready = 1'b0;

    // Redirect to 0x103 together with a response and a pop.
    tick(); #1;
    check("t4_rsp_arriving", 64'(mem_rsp_valid), 64'd1);
    dec_pkt_ready = 1'b1; redir_valid = 1'b1; redir_pc = 64'h103; redir_mask = 8'h33;
    tick(); #1;
    check("t4_empty", 64'(dec_pkt_valid), 64'd0);
    check("t4_req_valid", 64'(mem_req_valid), 64'd1);
    check("t4_req_aligned", mem_req_addr, 64'h100);
    tick(); tick(); #1;
    check("t4_pkt_mask", 64'(dec_pkt_mask), 64'h33);

    // halt with a simultaneous redirect: halt wins and fetch stops for good.
    halt = 1'b1; redir_valid = 1'b1; redir_pc = 64'h200; redir_mask = 8'h01; #1;
    check("t5_req_blocked", 64'(mem_req_valid), 64'd0);
    repeat (6) tick();
    #1;
    check("t5_halted_no_req", 64'(mem_req_valid), 64'd0);
    check("t5_halted_no_pkt", 64'(dec_pkt_valid), 64'd0);

    // Reset mid-WAIT with a stale response arriving while reset is held.
    rst_n = 1'b0; tick(); tick();
    rst_n = 1'b1; auto_mem = 1'b0; #1;
    check("t6_first_req", mem_req_addr, 64'd0);
    tick(); #1;
    check("t6_in_wait", 64'(mem_req_valid), 64'd0);
    rst_n = 1'b0;
    tick();
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEADBEEF; #1;
    check("t6_rst_no_pkt", 64'(dec_pkt_valid), 64'd0);
    tick();
    rst_n = 1'b1; auto_mem = 1'b1; #1;
    check("t6_restart_req", 64'(mem_req_valid), 64'd1);
    check("t6_restart_addr", mem_req_addr, 64'd0);
    check("t6_restart_no_pkt", 64'(dec_pkt_valid), 64'd0);
    tick(); tick(); #1;
    check("t6_pkt_valid", 64'(dec_pkt_valid), 64'd1);
    check("t6_pkt_insn", 64'(dec_pkt_insn), 64'd1);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
